// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and regfile write-port bundle
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               write_enable;
  logic [AW-1:0]      write_addr;
  logic [DW-1:0]      write_data;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, write_enable, write_addr, write_data
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, write_enable, write_addr, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the regfile write port
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_i,
  regfile_wb_arbiter_if.slave    bus,
  output logic [2:0]             grant_id_o,
  output logic [CW-1:0]          commit_cnt_o
);

  logic [2:0]      ptr_q;
  logic [2:0]      grant_id_q;
  logic            we_q;
  logic            we_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [CW-1:0]   cnt_q;

  logic            found;
  logic [2:0]      win;
  logic            grant;
  logic [NREQ-1:0] ready_vec;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Search begins one past the last winner so each source waits at most NREQ-1 grants.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    ready_vec = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = 3'((int'(ptr_q) + k) % NREQ);
      end
    end
    grant = found && !hold_i;
    if (grant && !rst) ready_vec[win] = 1'b1;
  end

  assign sel_addr = bus.req_addr[int'(win)*AW +: AW];
  assign sel_data = bus.req_data[int'(win)*DW +: DW];
  // r0 writes still complete the handshake but never reach the regfile.
  assign we_d     = grant && (sel_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 3'(NREQ - 1);
      grant_id_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      we_q <= we_d;
      if (grant) begin
        ptr_q      <= win;
        grant_id_q <= win;
        addr_q     <= sel_addr;
        data_q     <= sel_data;
      end
      if (we_d && (cnt_q != {CW{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.req_ready    = ready_vec;
  assign bus.write_enable = we_q;
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;
  assign grant_id_o       = grant_id_q;
  assign commit_cnt_o     = cnt_q;

endmodule
